// File: rtl/pong_pkg.sv
// Shared definitions for the Pong game-flow sequencer: state encoding,
// default timing constants and counter sizing helper.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_ATTRACT    = 3'd0,
    ST_START      = 3'd1,
    ST_SERVE_WAIT = 3'd2,
    ST_PLAY       = 3'd3,
    ST_POINT      = 3'd4,
    ST_OVER       = 3'd5
  } state_e;

  localparam int unsigned DEF_SERVE_FRAMES = 60;
  localparam int unsigned DEF_SRST_CYCLES  = 4;
  localparam int unsigned DEF_SCORE_W      = 2;
  localparam int unsigned DEF_FRAME_CNT_W  = 7;

  // The cycle counter must reach SRST_CYCLES-1 in START and SCORE_W in POINT.
  function automatic int unsigned cyc_cnt_w(input int unsigned srst_cycles,
                                            input int unsigned score_w);
    int unsigned m;
    m = (srst_cycles > score_w + 1) ? srst_cycles : score_w + 1;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pong_game_sequencer_if.sv
// Control/status bundle between the game sequencer and the surrounding
// score path, ball logic and coin handling.
interface pong_game_sequencer_if;
  logic       frame_tick;
  logic       coin;
  logic       _miss;
  logic       miss_left;
  logic       stop_g;
  logic       _attract;
  logic       srst;
  logic       _srst;
  logic       l;
  logic       r;
  logic       serve;
  logic [2:0] state_o;

  modport master (
    output frame_tick, coin, _miss, miss_left, stop_g,
    input  _attract, srst, _srst, l, r, serve, state_o
  );

  modport slave (
    input  frame_tick, coin, _miss, miss_left, stop_g,
    output _attract, srst, _srst, l, r, serve, state_o
  );
endinterface

// File: rtl/pong_edge_det.sv
// Registered falling-edge detector; a held-low level produces a single pulse.
module pong_edge_det #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic fall_o
);

  logic d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) d_q <= RST_VAL;
    else     d_q <= d_i;
  end

  assign fall_o = d_q & ~d_i;

endmodule

// File: rtl/pong_game_sequencer.sv
// Pong game-flow sequencer: attract -> start -> serve -> play -> point ->
// serve ... -> game over; drives score reset, score strobes and serve.
module pong_game_sequencer #(
  parameter int unsigned SERVE_FRAMES = pong_pkg::DEF_SERVE_FRAMES,
  parameter int unsigned SRST_CYCLES  = pong_pkg::DEF_SRST_CYCLES,
  parameter int unsigned SCORE_W      = pong_pkg::DEF_SCORE_W,
  parameter int unsigned FRAME_CNT_W  = pong_pkg::DEF_FRAME_CNT_W
) (
  input logic            mclk,
  input logic            rst,
  pong_game_sequencer_if.slave io
);
  import pong_pkg::*;

  localparam int unsigned CYC_W = cyc_cnt_w(SRST_CYCLES, SCORE_W);

  localparam logic [CYC_W-1:0]       SRST_LAST  = CYC_W'(SRST_CYCLES - 1);
  localparam logic [CYC_W-1:0]       SCORE_LAST = CYC_W'(SCORE_W);
  localparam logic [FRAME_CNT_W-1:0] FRM_LAST   = FRAME_CNT_W'(SERVE_FRAMES - 1);

  state_e                 state_q, state_d;
  logic [CYC_W-1:0]       cyc_q, cyc_d;
  logic [FRAME_CNT_W-1:0] frm_q, frm_d;
  logic                   side_q, side_d;
  logic                   serve_q, serve_d;
  logic                   miss_evt;

  pong_edge_det #(.RST_VAL(1'b1)) u_miss_det (
    .clk    (mclk),
    .rst    (rst),
    .d_i    (io._miss),
    .fall_o (miss_evt)
  );

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ATTRACT;
      cyc_q   <= '0;
      frm_q   <= '0;
      side_q  <= 1'b0;
      serve_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      frm_q   <= frm_d;
      side_q  <= side_d;
      serve_q <= serve_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    frm_d   = frm_q;
    side_d  = side_q;
    serve_d = 1'b0;
    unique case (state_q)
      ST_ATTRACT, ST_OVER: begin
        if (io.coin) begin
          state_d = ST_START;
          cyc_d   = '0;
        end
      end
      ST_START: begin
        if (cyc_q == SRST_LAST) begin
          state_d = ST_SERVE_WAIT;
          cyc_d   = '0;
          frm_d   = '0;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      ST_SERVE_WAIT: begin
        // The frame counter stops at FRM_LAST; the next tick launches the ball.
        if (io.frame_tick) begin
          if (frm_q == FRM_LAST) begin
            state_d = ST_PLAY;
            serve_d = 1'b1;
            cyc_d   = '0;
          end else begin
            frm_d = frm_q + FRAME_CNT_W'(1);
          end
        end
      end
      ST_PLAY: begin
        if (miss_evt) begin
          side_d  = io.miss_left;
          state_d = ST_POINT;
          cyc_d   = '0;
        end
      end
      ST_POINT: begin
        // Strobe occupies counts 0..SCORE_W-1; count SCORE_W is the settle cycle.
        if (cyc_q == SCORE_LAST) begin
          cyc_d = '0;
          if (io.stop_g) begin
            state_d = ST_OVER;
          end else begin
            state_d = ST_SERVE_WAIT;
            frm_d   = '0;
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      default: begin
        state_d = ST_ATTRACT;
        cyc_d   = '0;
      end
    endcase
  end

  logic srst, attract_n, strobe;

  always_comb begin
    srst      = (state_q == ST_ATTRACT) || (state_q == ST_START);
    attract_n = !((state_q == ST_ATTRACT) || (state_q == ST_OVER));
    strobe    = (state_q == ST_POINT) && (cyc_q < SCORE_LAST);
    io.srst     = srst;
    io._srst    = ~srst;
    io._attract = attract_n;
    io.l        = strobe & ~side_q;
    io.r        = strobe & side_q;
    io.serve    = serve_q;
    io.state_o  = state_q;
  end

endmodule
